// File: rtl/ddr3_init_refresh_seq_if.sv
// ddr3_init_refresh_seq_if
// Groups the DFI command bus and the refresh handshake between the
// init/refresh sequencer and the controller.
//   master : the sequencer. It drives the dfi_* outputs and bus_own_o,
//            cfg_done_o, ref_req_o and ref_err_o. It samples ref_gnt_i.
//   slave  : the controller or PHY mux. It drives ref_gnt_i and reads
//            everything else.
interface ddr3_init_refresh_seq_if #(
  parameter int ADDR_BITS = 14
);
  logic                 dfi_cke_o;
  logic                 dfi_rst_no;
  logic                 dfi_cs_no;
  logic                 dfi_ras_no;
  logic                 dfi_cas_no;
  logic                 dfi_we_no;
  logic                 dfi_odt_o;
  logic [2:0]           dfi_bank_o;
  logic [ADDR_BITS-1:0] dfi_addr_o;
  logic                 bus_own_o;
  logic                 cfg_done_o;
  logic                 ref_req_o;
  logic                 ref_gnt_i;
  logic                 ref_err_o;

  modport master (
    output dfi_cke_o, dfi_rst_no, dfi_cs_no, dfi_ras_no, dfi_cas_no,
           dfi_we_no, dfi_odt_o, dfi_bank_o, dfi_addr_o,
           bus_own_o, cfg_done_o, ref_req_o, ref_err_o,
    input  ref_gnt_i
  );

  modport slave (
    input  dfi_cke_o, dfi_rst_no, dfi_cs_no, dfi_ras_no, dfi_cas_no,
           dfi_we_no, dfi_odt_o, dfi_bank_o, dfi_addr_o,
           bus_own_o, cfg_done_o, ref_req_o, ref_err_o,
    output ref_gnt_i
  );
endinterface

// File: rtl/ddr3_init_refresh_seq.sv
// ddr3_init_refresh_seq
// Runs the DDR3 power-up and mode-register sequence on the DFI command bus:
// RESET# low, then CKE low, then tXPR, then MRS2/3/1/0, then ZQCL.
// After that it hands the bus to the controller and schedules periodic
// auto-refresh (PREA then REF) through a req/gnt handshake.
// Ports:
//   clock  : controller/PHY clock
//   reset  : synchronous, active-high
//   io_dfi : DFI command outputs plus the handshake (master side).
//            bus_own_o is high while this block drives the PHY.
//            cfg_done_o is sticky once init completes.
//            ref_req_o means at least one refresh is pending.
//            ref_gnt_i hands the bus over for one refresh.
//            ref_err_o is sticky and means the pending count overflowed.
module ddr3_init_refresh_seq #(
  parameter int                   ADDR_BITS = 14,
  parameter int                   T_RESET   = 20000,
  parameter int                   T_CKE     = 50000,
  parameter int                   T_XPR     = 17,
  parameter int                   T_MRD     = 4,
  parameter int                   T_MOD     = 12,
  parameter int                   T_ZQINIT  = 512,
  parameter int                   T_RP      = 6,
  parameter int                   T_RFC     = 16,
  parameter int                   T_REFI    = 780,
  parameter logic [ADDR_BITS-1:0] MR0       = 14'h0520,
  parameter logic [ADDR_BITS-1:0] MR1       = 14'h0044,
  parameter logic [ADDR_BITS-1:0] MR2       = 14'h0008,
  parameter logic [ADDR_BITS-1:0] MR3       = 14'h0000
) (
  input  logic                    clock,
  input  logic                    reset,
  ddr3_init_refresh_seq_if.master io_dfi
);

  function automatic int maxOf(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int MAX_T  = maxOf(maxOf(maxOf(T_RESET, T_CKE), maxOf(T_XPR, T_MRD)),
                                maxOf(maxOf(T_MOD, T_ZQINIT), maxOf(T_RP, T_RFC)));
  localparam int CNT_W  = $clog2(MAX_T + 1);
  localparam int REFI_W = $clog2(T_REFI + 1);

  // {cs_n, ras_n, cas_n, we_n}; DESEL is held until CKE rises
  localparam logic [3:0] CMD_DESEL = 4'b1111;
  localparam logic [3:0] CMD_NOP   = 4'b0111;
  localparam logic [3:0] CMD_MRS   = 4'b0000;
  localparam logic [3:0] CMD_REF   = 4'b0001;
  localparam logic [3:0] CMD_PREA  = 4'b0010;
  localparam logic [3:0] CMD_ZQCL  = 4'b0110;
  localparam logic [ADDR_BITS-1:0] ADDR_A10 = ADDR_BITS'(1 << 10);

  typedef enum logic [3:0] {
    ST_RST_LO, ST_CKE_LO, ST_XPR, ST_MRS2, ST_MRS3, ST_MRS1, ST_MRS0,
    ST_ZQCL, ST_IDLE, ST_PREA, ST_REF
  } state_t;

  state_t               r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_cke;
  logic                 r_rstN;
  logic [3:0]           r_cmd;
  logic [2:0]           r_bank;
  logic [ADDR_BITS-1:0] r_addr;
  logic                 r_busOwn;
  logic                 r_cfgDone;
  logic [REFI_W-1:0]    r_refiCnt;
  logic [3:0]           r_pending;
  logic                 r_refReq;
  logic                 r_refErr;

  logic       w_tick;
  logic       w_refIssue;
  logic [3:0] w_pendNext;
  logic       w_overflow;

  assign w_tick     = r_cfgDone && (r_refiCnt == '0);
  // The REF command goes out on the edge that leaves PREA
  assign w_refIssue = (r_state == ST_PREA) && (r_cnt == '0);

  // Pending-refresh bookkeeping. A tick and a REF in the same cycle cancel
  // out. The count stops at 8, the JEDEC postponement limit; a ninth tick
  // is flagged as an error instead of being counted.
  always_comb begin
    w_pendNext = r_pending;
    w_overflow = 1'b0;
    if (w_tick && !w_refIssue) begin
      if (r_pending == 4'd8) w_overflow = 1'b1;
      else                   w_pendNext = r_pending + 4'd1;
    end else if (!w_tick && w_refIssue && (r_pending != 4'd0)) begin
      w_pendNext = r_pending - 4'd1;
    end
  end

  // Single FSM with registered outputs. Each transition loads the shared
  // wait counter and drives that state's outputs on the same edge, so a
  // command lasts one cycle and the state then holds NOP until the counter
  // reaches zero.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= ST_RST_LO;
      r_cnt     <= CNT_W'(T_RESET - 1);
      r_cke     <= 1'b0;
      r_rstN    <= 1'b0;
      r_cmd     <= CMD_DESEL;
      r_bank    <= '0;
      r_addr    <= '0;
      r_busOwn  <= 1'b1;
      r_cfgDone <= 1'b0;
      r_refiCnt <= REFI_W'(T_REFI - 1);
      r_pending <= '0;
      r_refReq  <= 1'b0;
      r_refErr  <= 1'b0;
    end else begin
      if (r_cfgDone) begin
        r_refiCnt <= w_tick ? REFI_W'(T_REFI - 1) : r_refiCnt - REFI_W'(1);
      end
      r_pending <= w_pendNext;
      r_refReq  <= (w_pendNext != 4'd0);
      if (w_overflow) r_refErr <= 1'b1;

      if (r_cke) begin
        r_cmd  <= CMD_NOP;
        r_bank <= '0;
        r_addr <= '0;
      end
      if (r_cnt != '0) r_cnt <= r_cnt - CNT_W'(1);

      case (r_state)
        ST_RST_LO: if (r_cnt == '0) begin
          r_state <= ST_CKE_LO;
          r_rstN  <= 1'b1;
          r_cnt   <= CNT_W'(T_CKE - 1);
        end
        ST_CKE_LO: if (r_cnt == '0) begin
          r_state <= ST_XPR;
          r_cke   <= 1'b1;
          r_cmd   <= CMD_NOP;
          r_cnt   <= CNT_W'(T_XPR - 1);
        end
        ST_XPR: if (r_cnt == '0) begin
          r_state <= ST_MRS2;
          r_cmd   <= CMD_MRS;
          r_bank  <= 3'd2;
          r_addr  <= MR2;
          r_cnt   <= CNT_W'(T_MRD - 1);
        end
        ST_MRS2: if (r_cnt == '0) begin
          r_state <= ST_MRS3;
          r_cmd   <= CMD_MRS;
          r_bank  <= 3'd3;
          r_addr  <= MR3;
          r_cnt   <= CNT_W'(T_MRD - 1);
        end
        ST_MRS3: if (r_cnt == '0) begin
          r_state <= ST_MRS1;
          r_cmd   <= CMD_MRS;
          r_bank  <= 3'd1;
          r_addr  <= MR1;
          r_cnt   <= CNT_W'(T_MRD - 1);
        end
        ST_MRS1: if (r_cnt == '0) begin
          r_state <= ST_MRS0;
          r_cmd   <= CMD_MRS;
          r_bank  <= 3'd0;
          r_addr  <= MR0;
          r_cnt   <= CNT_W'(T_MOD - 1);
        end
        ST_MRS0: if (r_cnt == '0) begin
          r_state <= ST_ZQCL;
          r_cmd   <= CMD_ZQCL;
          r_addr  <= ADDR_A10;
          r_cnt   <= CNT_W'(T_ZQINIT - 1);
        end
        ST_ZQCL: if (r_cnt == '0) begin
          r_state   <= ST_IDLE;
          r_cfgDone <= 1'b1;
          r_busOwn  <= 1'b0;
        end
        ST_IDLE: if (r_refReq && io_dfi.ref_gnt_i) begin
          r_state  <= ST_PREA;
          r_busOwn <= 1'b1;
          r_cmd    <= CMD_PREA;
          r_addr   <= ADDR_A10;
          r_cnt    <= CNT_W'(T_RP - 1);
        end
        ST_PREA: if (r_cnt == '0) begin
          r_state <= ST_REF;
          r_cmd   <= CMD_REF;
          r_cnt   <= CNT_W'(T_RFC - 1);
        end
        ST_REF: if (r_cnt == '0) begin
          r_state  <= ST_IDLE;
          r_busOwn <= 1'b0;
        end
        default: r_state <= ST_RST_LO;
      endcase
    end
  end

  assign io_dfi.dfi_cke_o  = r_cke;
  assign io_dfi.dfi_rst_no = r_rstN;
  assign io_dfi.dfi_cs_no  = r_cmd[3];
  assign io_dfi.dfi_ras_no = r_cmd[2];
  assign io_dfi.dfi_cas_no = r_cmd[1];
  assign io_dfi.dfi_we_no  = r_cmd[0];
  assign io_dfi.dfi_odt_o  = 1'b0;
  assign io_dfi.dfi_bank_o = r_bank;
  assign io_dfi.dfi_addr_o = r_addr;
  assign io_dfi.bus_own_o  = r_busOwn;
  assign io_dfi.cfg_done_o = r_cfgDone;
  assign io_dfi.ref_req_o  = r_refReq;
  assign io_dfi.ref_err_o  = r_refErr;

endmodule
